// File: rtl/axi_arb_pkg.sv
// Shared types and constants for the AXI3 write-channel arbiter.
package axi_arb_pkg;

    localparam int unsigned ID_W        = 4;
    localparam int unsigned ADDR_W      = 32;
    localparam int unsigned DATA_W      = 32;
    localparam int unsigned STRB_W      = DATA_W / 8;
    localparam int unsigned AXI_LEN_W   = 4;
    localparam int unsigned AXI_SIZE_W  = 3;
    localparam int unsigned AXI_BURST_W = 2;
    localparam int unsigned AXI_RESP_W  = 2;

    localparam logic [AXI_RESP_W-1:0] RESP_OKAY   = 2'b00;
    localparam logic [AXI_RESP_W-1:0] RESP_SLVERR = 2'b10;

    typedef struct packed {
        logic [ID_W-1:0]        id;
        logic [ADDR_W-1:0]      addr;
        logic [AXI_LEN_W-1:0]   len;
        logic [AXI_SIZE_W-1:0]  size;
        logic [AXI_BURST_W-1:0] burst;
    } aw_t;

    typedef struct packed {
        logic [ID_W-1:0]   id;
        logic [DATA_W-1:0] data;
        logic [STRB_W-1:0] strb;
        logic              last;
    } w_t;

    typedef struct packed {
        logic [ID_W-1:0]       id;
        logic [AXI_RESP_W-1:0] resp;
    } b_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_AW   = 2'd1,
        ST_W    = 2'd2,
        ST_B    = 2'd3
    } arb_state_e;

    // Width of an index able to address n masters (at least one bit).
    function automatic int unsigned idx_w(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/axi_wr_arbiter_rr_pick.sv
// Combinational round-robin picker: first requester strictly after last_grant.
module axi_rr_pick #(
    parameter int unsigned NM    = 2,
    parameter int unsigned IDX_W = 1
) (
    input  logic [NM-1:0]    req,
    input  logic [IDX_W-1:0] last_grant,
    output logic [NM-1:0]    gnt,
    output logic [IDX_W-1:0] gnt_idx,
    output logic             any
);

    logic [IDX_W-1:0] cand;

    // Walk the masters starting one past the previous owner, wrapping around.
    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        any     = 1'b0;
        cand    = '0;
        for (int unsigned k = 1; k <= NM; k++) begin
            cand = IDX_W'((32'(last_grant) + k) % NM);
            if (!any && req[cand]) begin
                gnt[cand] = 1'b1;
                gnt_idx   = cand;
                any       = 1'b1;
            end
        end
    end

endmodule

// File: rtl/axi_wr_arbiter.sv
// AXI3 write-path arbiter: NM masters share one AW/W/B path, one locked transaction at a time.
module axi_wr_arbiter
    import axi_arb_pkg::*;
#(
    parameter int unsigned NM = 2
) (
    input  logic          ACLK,
    input  logic          ARESETn,
    input  aw_t           S_AW [NM],
    input  logic [NM-1:0] S_AWVALID,
    output logic [NM-1:0] S_AWREADY,
    input  w_t            S_W [NM],
    input  logic [NM-1:0] S_WVALID,
    output logic [NM-1:0] S_WREADY,
    output b_t            S_B,
    output logic [NM-1:0] S_BVALID,
    input  logic [NM-1:0] S_BREADY,
    output aw_t           M_AW,
    output logic          M_AWVALID,
    input  logic          M_AWREADY,
    output w_t            M_W,
    output logic          M_WVALID,
    input  logic          M_WREADY,
    input  b_t            M_B,
    input  logic          M_BVALID,
    output logic          M_BREADY,
    output logic [NM-1:0] grant,
    output logic          err_wlast
);

    localparam int unsigned      IDX_W     = idx_w(NM);
    localparam logic [IDX_W-1:0] LAST_INIT = IDX_W'(NM - 1);

    arb_state_e           state, state_nxt;
    logic [IDX_W-1:0]     owner;
    logic [IDX_W-1:0]     last_grant;
    logic [AXI_LEN_W-1:0] beat_cnt;
    logic                 cnt_zero;
    logic [NM-1:0]        pick_gnt;
    logic [IDX_W-1:0]     pick_idx;
    logic                 pick_any;
    logic                 aw_hs, w_hs, b_hs;

    assign cnt_zero = (beat_cnt == '0);

    axi_rr_pick #(
        .NM    (NM),
        .IDX_W (IDX_W)
    ) u_pick (
        .req        (S_AWVALID),
        .last_grant (last_grant),
        .gnt        (pick_gnt),
        .gnt_idx    (pick_idx),
        .any        (pick_any)
    );

    // State register.
    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state and channel routing; only the registered owner is ever muxed through.
    always_comb begin
        state_nxt = state;
        S_AWREADY = '0;
        S_WREADY  = '0;
        S_BVALID  = '0;
        S_B       = M_B;
        M_AW      = '0;
        M_AWVALID = 1'b0;
        M_W       = '0;
        M_WVALID  = 1'b0;
        M_BREADY  = 1'b0;
        err_wlast = 1'b0;
        aw_hs     = 1'b0;
        w_hs      = 1'b0;
        b_hs      = 1'b0;
        case (state)
            ST_IDLE: begin
                if (pick_any) begin
                    state_nxt = ST_AW;
                end
            end
            ST_AW: begin
                M_AW             = S_AW[owner];
                M_AWVALID        = S_AWVALID[owner];
                S_AWREADY[owner] = M_AWREADY;
                aw_hs            = M_AWVALID && M_AWREADY;
                if (aw_hs) begin
                    state_nxt = ST_W;
                end
            end
            ST_W: begin
                M_W             = S_W[owner];
                M_W.last        = cnt_zero;
                M_WVALID        = S_WVALID[owner];
                S_WREADY[owner] = M_WREADY;
                w_hs            = M_WVALID && M_WREADY;
                err_wlast       = w_hs && (S_W[owner].last != cnt_zero);
                if (w_hs && cnt_zero) begin
                    state_nxt = ST_B;
                end
            end
            ST_B: begin
                S_BVALID[owner] = M_BVALID;
                M_BREADY        = S_BREADY[owner];
                b_hs            = M_BVALID && M_BREADY;
                if (b_hs) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    // Owner, round-robin pointer and remaining-beat counter.
    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            grant      <= '0;
            owner      <= '0;
            last_grant <= LAST_INIT;
            beat_cnt   <= '0;
        end else begin
            if ((state == ST_IDLE) && pick_any) begin
                grant <= pick_gnt;
                owner <= pick_idx;
            end
            if (aw_hs) begin
                beat_cnt <= S_AW[owner].len;
            end
            if (w_hs && !cnt_zero) begin
                beat_cnt <= beat_cnt - AXI_LEN_W'(1);
            end
            if (b_hs) begin
                last_grant <= owner;
                grant      <= '0;
            end
        end
    end

endmodule

// File: tb/tb_axi_wr_arbiter.sv
// Randomised bench for axi_wr_arbiter against a transaction-level model.
module tb_axi_wr_arbiter;
    import axi_arb_pkg::*;

    localparam int unsigned NM   = 2;
    localparam int          NM_I = 2;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    aw_t           s_aw [NM];
    logic [NM-1:0] s_awvalid, s_awready;
    w_t            s_w [NM];
    logic [NM-1:0] s_wvalid, s_wready;
    b_t            s_b;
    logic [NM-1:0] s_bvalid, s_bready;
    aw_t           m_aw;
    logic          m_awvalid, m_awready;
    w_t            m_w;
    logic          m_wvalid, m_wready;
    b_t            m_b;
    logic          m_bvalid, m_bready;
    logic [NM-1:0] grant;
    logic          err_wlast;

    axi_wr_arbiter #(.NM(NM)) dut (
        .ACLK(clk), .ARESETn(rst_n),
        .S_AW(s_aw), .S_AWVALID(s_awvalid), .S_AWREADY(s_awready),
        .S_W(s_w), .S_WVALID(s_wvalid), .S_WREADY(s_wready),
        .S_B(s_b), .S_BVALID(s_bvalid), .S_BREADY(s_bready),
        .M_AW(m_aw), .M_AWVALID(m_awvalid), .M_AWREADY(m_awready),
        .M_W(m_w), .M_WVALID(m_wvalid), .M_WREADY(m_wready),
        .M_B(m_b), .M_BVALID(m_bvalid), .M_BREADY(m_bready),
        .grant(grant), .err_wlast(err_wlast)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [1:0]       m;
        logic [ID_W-1:0]  id;
        logic [31:0]      addr;
        logic [3:0]       len;
        logic [31:0]      seed;
        logic [4:0]       bad;     // beat whose LAST is driven wrong; 16 = none
        logic [1:0]       resp;
        logic [ID_W-1:0]  bid;
    } txn_t;

    txn_t pend[$];
    int   order[$];
    int   n_checks = 0;
    int   n_pass = 0;

    // transaction-level model
    int   owner = -1;
    logic aw_done = 1'b0;
    int   last_served = NM_I - 1;
    int   aw_cyc = 0;
    logic aw_sent [NM];
    int   wbeat [NM];
    logic wv [NM];
    logic sbv = 1'b0;
    logic in_aw, in_w, in_b;
    txn_t ot;

    // knobs
    int   awmode = 0, wmode = 0, wprob = 100, rprob = 100, bprob = 100, bvprob = 100;
    logic wtog = 1'b1;
    int   err_seen = 0;
    b_t   b_got [NM];
    aw_t  prev_aw;
    w_t   prev_w;
    logic prev_aw_stall = 1'b0, prev_w_stall = 1'b0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        assert (got === exp) n_pass++;
        else $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    function automatic int first_of(input int m);
        foreach (pend[i]) if (int'(pend[i].m) == m) return i;
        return -1;
    endfunction

    function automatic int rr_pick(input int last, input logic [NM-1:0] req);
        for (int k = 1; k <= NM_I; k++) begin
            int c;
            c = (last + k) % NM_I;
            if (req[c]) return c;
        end
        return -1;
    endfunction

    function automatic aw_t exp_aw(input txn_t t);
        aw_t a;
        a.id = t.id; a.addr = t.addr; a.len = t.len; a.size = 3'd2; a.burst = 2'b01;
        return a;
    endfunction

    function automatic w_t beat_w(input txn_t t, input int k, input logic honest);
        w_t w;
        logic correct_last;
        correct_last = (k == int'(t.len));
        w.id   = t.id;
        w.data = t.seed + 32'(k);
        w.strb = t.seed[3:0] ^ 4'(k);
        w.last = (!honest && (k == int'(t.bad))) ? !correct_last : correct_last;
        return w;
    endfunction

    function automatic txn_t mk(input int m, input int id, input int addr, input int len,
                                input int seed, input int bad, input logic [1:0] resp, input int bid);
        txn_t t;
        t.m = 2'(m); t.id = ID_W'(id); t.addr = 32'(addr); t.len = 4'(len);
        t.seed = 32'(seed); t.bad = 5'(bad); t.resp = resp; t.bid = ID_W'(bid);
        return t;
    endfunction

    function automatic logic coin(input int pct);
        return int'($urandom_range(99)) < pct;
    endfunction

    task automatic clear_inputs();
        for (int m = 0; m < NM_I; m++) begin
            s_aw[m] = '0; s_w[m] = '0;
        end
        s_awvalid = '0; s_wvalid = '0; s_bready = '0;
        m_awready = 1'b0; m_wready = 1'b0; m_bvalid = 1'b0; m_b = '0;
    endtask

    task automatic model_reset();
        pend.delete();
        owner = -1; aw_done = 1'b0; last_served = NM_I - 1; aw_cyc = 0; sbv = 1'b0;
        prev_aw_stall = 1'b0; prev_w_stall = 1'b0;
        for (int m = 0; m < NM_I; m++) begin
            aw_sent[m] = 1'b0; wbeat[m] = 0; wv[m] = 1'b0;
        end
    endtask

    task automatic knobs(input int awm, input int wm, input int wp, input int rp, input int bp, input int bvp);
        awmode = awm; wmode = wm; wprob = wp; rprob = rp; bprob = bp; bvprob = bvp;
    endtask

    task automatic drive();
        for (int m = 0; m < NM_I; m++) begin
            int i;
            i = first_of(m);
            if (i < 0) begin
                s_awvalid[m] = 1'b0; s_wvalid[m] = 1'b0; s_aw[m] = '0; s_w[m] = '0; wv[m] = 1'b0;
            end else begin
                txn_t t;
                t = pend[i];
                s_aw[m] = exp_aw(t);
                s_awvalid[m] = !aw_sent[m];
                if (wbeat[m] <= int'(t.len)) begin
                    if (!wv[m]) wv[m] = coin(wprob);
                    s_wvalid[m] = wv[m];
                    s_w[m] = beat_w(t, wbeat[m], 1'b0);
                end else begin
                    s_wvalid[m] = 1'b0; s_w[m] = '0;
                end
            end
            s_bready[m] = coin(bprob);
        end
        in_aw = (owner >= 0) && !aw_done;
        in_w  = 1'b0;
        in_b  = 1'b0;
        if (owner >= 0) begin
            ot = pend[first_of(owner)];
            in_w = aw_done && (wbeat[owner] <= int'(ot.len));
            in_b = aw_done && !in_w;
        end
        m_awready = (awmode != 0) ? (in_aw && aw_cyc >= 5) : coin(rprob);
        m_wready  = (wmode != 0) ? wtog : coin(rprob);
        if (!in_b) sbv = 1'b0;
        else if (!sbv) sbv = coin(bvprob);
        m_bvalid = sbv;
        if (in_b) begin
            m_b.id = ot.bid; m_b.resp = ot.resp;
        end else begin
            m_b = b_t'(6'($urandom));
        end
    endtask

    task automatic check_outputs();
        logic [NM-1:0] gexp, awr, wr, bv;
        logic exp_awv, exp_wv, exp_br, exp_err;
        gexp = '0; awr = '0; wr = '0; bv = '0;
        exp_awv = 1'b0; exp_wv = 1'b0; exp_br = 1'b0; exp_err = 1'b0;
        if (owner >= 0) gexp[owner] = 1'b1;
        if (in_aw) begin
            awr[owner] = m_awready; exp_awv = s_awvalid[owner];
        end
        if (in_w) begin
            wr[owner] = m_wready; exp_wv = s_wvalid[owner];
            exp_err = s_wvalid[owner] && m_wready &&
                      (s_w[owner].last != (wbeat[owner] == int'(ot.len)));
        end
        if (in_b) begin
            bv[owner] = m_bvalid; exp_br = s_bready[owner];
        end
        chk("grant", 64'(grant), 64'(gexp));
        chk("s_awready", 64'(s_awready), 64'(awr));
        chk("m_awvalid", 64'(m_awvalid), 64'(exp_awv));
        if (exp_awv) chk("m_aw", 64'(m_aw), 64'(exp_aw(ot)));
        chk("s_wready", 64'(s_wready), 64'(wr));
        chk("m_wvalid", 64'(m_wvalid), 64'(exp_wv));
        if (exp_wv) chk("m_w", 64'(m_w), 64'(beat_w(ot, wbeat[owner], 1'b1)));
        chk("err_wlast", 64'(err_wlast), 64'(exp_err));
        chk("s_bvalid", 64'(s_bvalid), 64'(bv));
        chk("m_bready", 64'(m_bready), 64'(exp_br));
        if (in_b && m_bvalid) chk("s_b", 64'(s_b), 64'(m_b));
        if (prev_aw_stall && m_awvalid) chk("aw_stable", 64'(m_aw), 64'(prev_aw));
        if (prev_w_stall && m_wvalid) chk("w_stable", 64'(m_w), 64'(prev_w));
        prev_aw_stall = m_awvalid && !m_awready; prev_aw = m_aw;
        prev_w_stall  = m_wvalid && !m_wready;   prev_w  = m_w;
        if (err_wlast) err_seen++;
    endtask

    task automatic update();
        if (owner < 0) begin
            logic [NM-1:0] req;
            req = '0;
            for (int m = 0; m < NM_I; m++) req[m] = (first_of(m) >= 0) && !aw_sent[m];
            if (req != '0) begin
                owner = rr_pick(last_served, req); aw_done = 1'b0; aw_cyc = 0;
            end
        end else if (in_aw) begin
            aw_cyc++;
            if (s_awvalid[owner] && m_awready) begin
                aw_done = 1'b1; aw_sent[owner] = 1'b1;
            end
        end else if (in_w) begin
            if (s_wvalid[owner] && m_wready) begin
                wbeat[owner]++; wv[owner] = 1'b0;
            end
        end else if (m_bvalid && s_bready[owner]) begin
            b_got[owner] = s_b;
            pend.delete(first_of(owner));
            order.push_back(owner);
            aw_sent[owner] = 1'b0; wbeat[owner] = 0; wv[owner] = 1'b0; sbv = 1'b0;
            last_served = owner; owner = -1;
        end
    endtask

    task automatic cycle();
        @(negedge clk);
        drive();
        #1;
        check_outputs();
        update();
        wtog = ~wtog;
    endtask

    task automatic run(input string tag, input int maxc);
        int c;
        c = 0;
        while (pend.size() > 0 && c < maxc) begin
            cycle();
            c++;
        end
        chk({tag, "_drain"}, 64'(pend.size()), 64'(0));
    endtask

    task automatic chk_idle_outs(input string tag);
        chk(tag, 64'({grant, s_awready, s_wready, s_bvalid, m_awvalid, m_wvalid, m_bready, err_wlast}), 64'(0));
    endtask

    initial begin
        b_t bexp;
        model_reset();
        // Reset state with every input pulling the other way.
        clear_inputs();
        s_awvalid = '1; s_wvalid = '1; s_bready = '1;
        m_awready = 1'b1; m_wready = 1'b1; m_bvalid = 1'b1;
        #12;
        chk_idle_outs("reset_outs");
        clear_inputs();
        @(negedge clk);
        rst_n = 1'b1;

        // Contention straight after reset: master 0 first, then alternate.
        knobs(0, 0, 100, 100, 100, 100);
        pend.push_back(mk(0, 1, 'h200, 1, 'h10, 16, RESP_OKAY, 1));
        pend.push_back(mk(1, 2, 'h300, 2, 'h20, 16, RESP_OKAY, 2));
        run("contend1", 200);
        pend.push_back(mk(0, 3, 'h400, 0, 'h30, 16, RESP_OKAY, 3));
        pend.push_back(mk(1, 4, 'h500, 1, 'h40, 16, RESP_OKAY, 4));
        run("contend2", 200);
        chk("order_len", 64'(order.size()), 64'(4));
        for (int i = 0; i < 4 && i < order.size(); i++) chk("order", 64'(order[i]), 64'(i % 2));
        order.delete();

        // Single master burst, data 0xA0..0xA3, OKAY response.
        pend.push_back(mk(0, 6, 'h100, 3, 'hA0, 16, RESP_OKAY, 6));
        run("single", 100);
        bexp.id = 4'h6; bexp.resp = RESP_OKAY;
        chk("single_b", 64'(b_got[0]), 64'(bexp));
        cycle();

        // Backpressure: AWREADY held off 5 cycles, WREADY toggling.
        knobs(1, 1, 100, 100, 100, 100);
        pend.push_back(mk(1, 7, 'h600, 5, 'h50, 16, RESP_OKAY, 7));
        pend.push_back(mk(0, 8, 'h700, 2, 'h60, 16, RESP_OKAY, 8));
        run("backpr", 300);

        // WLAST error on master 1, beat 0 of a two-beat burst.
        knobs(0, 0, 100, 100, 100, 100);
        err_seen = 0;
        pend.push_back(mk(1, 9, 'h800, 1, 'h70, 0, RESP_OKAY, 9));
        run("wlast", 100);
        chk("wlast_pulses", 64'(err_seen), 64'(1));

        // Slave error routed to master 0 while master 1 waits.
        pend.push_back(mk(0, 10, 'h900, 2, 'h80, 16, RESP_SLVERR, 5));
        pend.push_back(mk(1, 11, 'hA00, 1, 'h90, 16, RESP_OKAY, 11));
        run("slverr", 200);
        bexp.id = 4'h5; bexp.resp = RESP_SLVERR;
        chk("slverr_b", 64'(b_got[0]), 64'(bexp));

        // Randomised traffic.
        knobs(0, 0, 60, 70, 70, 60);
        for (int i = 0; i < 24; i++) begin
            int len, bad;
            len = int'($urandom_range(15));
            bad = coin(20) ? int'($urandom_range(len)) : 16;
            pend.push_back(mk(int'($urandom_range(NM - 1)), int'($urandom_range(15)),
                              int'($urandom), len, int'($urandom), bad,
                              2'($urandom), int'($urandom_range(15))));
        end
        run("random", 5000);

        // Reset during beat 2 of an eight-beat burst.
        knobs(0, 0, 100, 100, 100, 100);
        pend.push_back(mk(0, 12, 'hB00, 7, 'hC0, 16, RESP_OKAY, 12));
        begin
            int c;
            c = 0;
            while (!(owner == 0 && aw_done && wbeat[0] == 2) && c < 300) begin
                cycle();
                c++;
            end
            chk("midrst_reach", 64'(wbeat[0]), 64'(2));
        end
        @(negedge clk);
        drive();
        s_wvalid[0] = 1'b1; m_wready = 1'b1; s_bready = '1; m_bvalid = 1'b1; m_awready = 1'b1;
        #1;
        chk("midrst_pre", 64'(m_wvalid), 64'(1));
        rst_n = 1'b0;
        #1;
        chk_idle_outs("midrst_outs");
        clear_inputs();
        model_reset();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        pend.push_back(mk(0, 13, 'hC00, 0, 'hD0, 16, RESP_OKAY, 13));
        run("postrst", 100);
        bexp.id = 4'hD; bexp.resp = RESP_OKAY;
        chk("postrst_b", 64'(b_got[0]), 64'(bexp));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
